// File: rtl/nes_bus_pkg.sv
// Shared NES bus constants and the OAM DMA state encoding.
// Imported by the OAM DMA engine and any block decoding the bus.
package nes_bus_pkg;

   localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
   localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to $4014 halts the CPU and copies one
// 256-byte page to OAMDATA ($2004) as alternating read/write bus cycles.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   cpu_addr/rw/data_out  - CPU bus request (rw: 1 = read)
//   mem_data              - memory read data for the previous address cycle
//   bus_addr/rw/data      - muxed bus toward memory
//   rdy                   - CPU ready (0 halts the CPU)
//   dma_active            - high whenever the engine is not idle
module oam_dma
   import nes_bus_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rw,
   input  logic [7:0]  cpu_data_out,
   input  logic [7:0]  mem_data,
   output logic [15:0] bus_addr,
   output logic        bus_rw,
   output logic [7:0]  bus_data,
   output logic        rdy,
   output logic        dma_active
);

   dma_state_t state;
   logic       phase;
   logic [7:0] page;
   logic [7:0] index;
   logic [7:0] data;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         phase <= 1'b0;
         page  <= 8'h00;
         index <= 8'h00;
         data  <= 8'h00;
      end else begin
         phase <= ~phase;
         unique case (state)
            IDLE: begin
               if (cpu_addr == OAMDMA_ADDR && !cpu_rw) begin
                  page  <= cpu_data_out;
                  index <= 8'h00;
                  state <= HALT;
               end
            end
            HALT: begin
               // Wait out CPU writes; the next phase is get when the
               // current phase is put, so reads always land on get.
               if (cpu_rw)
                  state <= phase ? READ : ALIGN;
            end
            ALIGN: state <= READ;
            READ: begin
               data  <= mem_data;
               state <= WRITE;
            end
            WRITE: begin
               if (index == 8'hFF) begin
                  state <= IDLE;
               end else begin
                  index <= index + 8'd1;
                  state <= READ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus_addr = cpu_addr;
      bus_rw   = cpu_rw;
      bus_data = data;
      rdy      = 1'b0;
      unique case (state)
         IDLE: begin
            bus_data = cpu_data_out;
            rdy      = 1'b1;
         end
         HALT: ;
         ALIGN: bus_rw = 1'b1;
         READ: begin
            bus_addr = {page, index};
            bus_rw   = 1'b1;
         end
         WRITE: begin
            bus_addr = OAMDATA_ADDR;
            bus_rw   = 1'b0;
         end
         default: rdy = 1'b1;
      endcase
   end

   assign dma_active = (state != IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected DMA reads/writes are queued at
// trigger time and popped as the engine issues bus cycles.
module tb_oam_dma;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic [7:0]  cpu_data_out;
   logic [7:0]  mem_data;
   logic [15:0] bus_addr;
   logic        bus_rw;
   logic [7:0]  bus_data;
   logic        rdy;
   logic        dma_active;

   oam_dma dut (
      .clock        (clock),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_rw       (cpu_rw),
      .cpu_data_out (cpu_data_out),
      .mem_data     (mem_data),
      .bus_addr     (bus_addr),
      .bus_rw       (bus_rw),
      .bus_data     (bus_data),
      .rdy          (rdy),
      .dma_active   (dma_active)
   );

   always #5 clock = ~clock;

   // Memory image: page $02 holds i^$A5, other pages are distinct.
   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
   endfunction

   assign mem_data = mem_f(bus_addr);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference phase: 0 after reset, toggles every clock.
   logic tb_phase = 1'b0;
   always @(posedge clock) tb_phase <= reset ? 1'b0 : ~tb_phase;

   logic [15:0] rd_q[$];
   logic [7:0]  wr_q[$];
   int          rdy_low = 0;
   int          n_rd = 0;
   int          n_wr = 0;
   logic [15:0] last_rd = 16'h0000;

   always @(negedge clock) begin
      if (!rdy) rdy_low++;
      if (dma_active && bus_rw && bus_addr != cpu_addr) begin
         n_rd++;
         last_rd = bus_addr;
         if (rd_q.size() == 0) chk("rd_unexpected", rd_q.size(), 1);
         else chk("rd_addr", bus_addr, rd_q.pop_front());
      end
      if (dma_active && !bus_rw && bus_addr == 16'h2004) begin
         n_wr++;
         if (wr_q.size() == 0) chk("wr_unexpected", wr_q.size(), 1);
         else chk("wr_data", bus_data, wr_q.pop_front());
      end
   end

   task automatic arm(input logic [7:0] page);
      for (int i = 0; i < 256; i++) begin
         logic [15:0] a;
         a = {page, i[7:0]};
         rd_q.push_back(a);
         wr_q.push_back(mem_f(a));
      end
      rdy_low = 0;
      n_rd = 0;
      n_wr = 0;
   endtask

   // Trigger so the phase before the trigger edge equals want_phase
   // (0 -> no ALIGN), then hold CPU writes for hold_w cycles.
   task automatic trigger(input logic [7:0] page, input logic want_phase,
                          input int hold_w);
      int k;
      @(negedge clock);
      k = 0;
      while (tb_phase != want_phase && k < 4) begin
         @(negedge clock);
         k++;
      end
      cpu_addr = 16'h4014;
      cpu_rw = 1'b0;
      cpu_data_out = page;
      arm(page);
      @(negedge clock);
      for (int h = 0; h < hold_w; h++) begin
         cpu_addr = 16'h0300;
         cpu_rw = 1'b0;
         cpu_data_out = 8'h5A;
         #1;
         chk("halt_addr", bus_addr, 16'h0300);
         chk("halt_rw", bus_rw, 1'b0);
         chk("halt_rdy", rdy, 1'b0);
         @(negedge clock);
      end
      cpu_addr = 16'h8000;
      cpu_rw = 1'b1;
      cpu_data_out = 8'h00;
   endtask

   task automatic finish_xfer(input string tag, input int exp_low);
      int k;
      k = 0;
      while (dma_active && k < 2000) begin
         @(negedge clock);
         k++;
      end
      chk({tag, "_timeout"}, dma_active, 1'b0);
      chk({tag, "_rdy_back"}, rdy, 1'b1);
      @(negedge clock);
      #1;
      chk({tag, "_rdy_low"}, rdy_low, exp_low);
      chk({tag, "_n_rd"}, n_rd, 256);
      chk({tag, "_n_wr"}, n_wr, 256);
      chk({tag, "_rdq_left"}, rd_q.size(), 0);
      chk({tag, "_wrq_left"}, wr_q.size(), 0);
   endtask

   initial begin
      int k;
      cpu_addr = 16'h8000;
      cpu_rw = 1'b1;
      cpu_data_out = 8'h00;
      repeat (3) @(negedge clock);
      chk("rst_rdy", rdy, 1'b1);
      chk("rst_active", dma_active, 1'b0);
      chk("rst_bus_addr", bus_addr, 16'h8000);
      reset = 1'b0;

      // Idle passthrough
      @(negedge clock);
      cpu_addr = 16'h1234;
      cpu_rw = 1'b0;
      cpu_data_out = 8'h77;
      #1;
      chk("idle_addr", bus_addr, 16'h1234);
      chk("idle_rw", bus_rw, 1'b0);
      chk("idle_data", bus_data, 8'h77);

      // Non-triggers: write $4015, read $4014
      @(negedge clock);
      cpu_addr = 16'h4015;
      cpu_rw = 1'b0;
      cpu_data_out = 8'h02;
      @(negedge clock);
      cpu_addr = 16'h4014;
      cpu_rw = 1'b1;
      @(negedge clock);
      cpu_addr = 16'h8000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("notrig_active", dma_active, 1'b0);
         chk("notrig_rdy", rdy, 1'b1);
      end

      // Page $02, no ALIGN
      trigger(8'h02, 1'b0, 0);
      finish_xfer("noalign", 513);

      // Opposite phase -> one ALIGN cycle
      trigger(8'h02, 1'b1, 0);
      finish_xfer("align", 514);

      // CPU still writing for two cycles after the trigger
      trigger(8'h02, 1'b0, 2);
      finish_xfer("hold2", 515);

      // Page $FF with an ignored $4014 write mid-transfer
      trigger(8'hFF, 1'b0, 0);
      repeat (100) @(negedge clock);
      cpu_addr = 16'h4014;
      cpu_rw = 1'b0;
      cpu_data_out = 8'h11;
      @(negedge clock);
      cpu_addr = 16'h8000;
      cpu_rw = 1'b1;
      cpu_data_out = 8'h00;
      finish_xfer("pageff", 513);

      // Reset while writing index $40
      trigger(8'h02, 1'b0, 0);
      k = 0;
      while (k < 1000) begin
         @(posedge clock);
         #1;
         if (dma_active && !bus_rw && bus_addr == 16'h2004 &&
             last_rd == 16'h0240) break;
         k++;
      end
      chk("rst_found_idx40", last_rd, 16'h0240);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("abort_rdy", rdy, 1'b1);
      chk("abort_active", dma_active, 1'b0);
      chk("abort_bus_addr", bus_addr, cpu_addr);
      reset = 1'b0;
      chk("abort_n_wr", n_wr, 65);
      rd_q.delete();
      wr_q.delete();
      repeat (20) @(negedge clock);
      #1;
      chk("abort_no_more_wr", n_wr, 65);
      chk("abort_no_more_rd", n_rd, 65);
      chk("abort_idle", dma_active, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 clock  input  1  system clock; all state updates on posedge clock.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 cpu_addr  input  16  address driven by the CPU.
REQ-004 cpu_rw  input  1  CPU read/write strobe; 1 = read, 0 = write.
REQ-005 cpu_data_out  input  8  CPU write data.
REQ-006 mem_data  input  8  memory read data, valid at the posedge following the address cycle.
REQ-007 bus_addr  output  16  address to memory/bus.
REQ-008 bus_rw  output  1  read/write strobe to memory/bus.
REQ-009 bus_data  output  8  write data to memory/bus.
REQ-010 rdy  output  1  CPU ready; 0 halts the CPU, which SHALL repeat its current read cycle.
REQ-011 dma_active  output  1  1 while the state is not IDLE.

Function
REQ-012 The block SHALL hold a phase bit that toggles every clock: 0 = get, 1 = put.
REQ-013 In IDLE, bus_addr, bus_rw and bus_data SHALL pass cpu_addr, cpu_rw and cpu_data_out through combinationally.
REQ-014 In IDLE, rdy SHALL be 1.
REQ-015 Trigger: a posedge sampling cpu_addr=$4014 with cpu_rw=0 in IDLE SHALL latch cpu_data_out into page and enter HALT.
REQ-016 Reads of $4014, and writes to any other address, SHALL NOT trigger.
REQ-017 HALT: rdy=0 and the bus SHALL pass the CPU through.
REQ-018 HALT exit when cpu_rw=1: go to READ if the next phase is get, otherwise go to ALIGN.
REQ-019 HALT with cpu_rw=0: remain in HALT (CPU still completing a write).
REQ-020 ALIGN: one dummy cycle; bus_addr=cpu_addr, bus_rw=1, rdy=0; then go to READ.
REQ-021 READ: bus_addr={page,index}, bus_rw=1, rdy=0; at the next posedge latch mem_data into the data latch and go to WRITE.
REQ-022 WRITE: bus_addr=$2004, bus_rw=0, bus_data=data latch, rdy=0.
REQ-023 On leaving WRITE: if index=$FF go to IDLE, otherwise increment index and go to READ.
REQ-024 index SHALL be 8 bits; page SHALL never change during a transfer (no carry into the page, no wrap to the next page).
REQ-025 Total rdy-low time SHALL be 513 cycles, or 514 when ALIGN is used, assuming a single HALT cycle.
REQ-026 rdy SHALL return to 1 in the first cycle after the final WRITE.
REQ-027 index SHALL reset to 0 on entry to HALT.
REQ-028 Writes to $4014 while not IDLE SHALL be ignored.
REQ-029 dma_active SHALL be a function of the registered state only.
REQ-030 In every non-IDLE state, bus_data SHALL equal the data latch.

Reset
REQ-031 Reset SHALL set: state=IDLE, phase=0, page=$00, index=$00, data latch=$00.
REQ-032 Resulting output values after reset: rdy=1, dma_active=0, bus passthrough.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer on the next posedge, with no further DMA bus cycles.

Structure
REQ-034 Constants OAMDMA_ADDR=$4014 and OAMDATA_ADDR=$2004, and the state encoding (IDLE, HALT, ALIGN, READ, WRITE), SHALL live in shared package nes_bus_pkg.
REQ-035 No sub-module is required; the phase bit, counter and FSM SHALL live in one module.
REQ-036 The block SHALL sit between cpu_2a03 and the memory; cpu_2a03 rdy SHALL be driven from this block.

Verification
REQ-037 Page $02, no ALIGN: preload $0200+i=i^$A5, write $02 to $4014 with the next phase get -> 513 rdy-low cycles, 256 alternating reads $0200..$02FF / writes $2004, write data = i^$A5 in order.
REQ-038 Same stimulus one cycle later (opposite phase) -> exactly one ALIGN cycle, 514 rdy-low cycles, identical write sequence.
REQ-039 CPU presents cpu_rw=0 for two cycles after the trigger -> HALT held for those two cycles, then READ/ALIGN; no DMA bus cycle is issued during the CPU writes.
REQ-040 Assert reset when index=$40 in WRITE -> next cycle rdy=1, dma_active=0, bus_addr=cpu_addr, and no further $2004 writes.
REQ-041 Write $4015=$02 and read $4014 -> rdy stays 1 and no DMA occurs; page $FF -> reads $FF00..$FFFF only, never $0000.
